// File: rtl/ivs_pkg.sv
// Shared types for the IVS slot command fetcher: FSM states and error causes.
package ivs_pkg;

  localparam int unsigned ERR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2,
    ST_OUT  = 2'd3
  } ivs_state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE       = 2'd0,
    ERR_EARLY_LAST = 2'd1,
    ERR_MISS_LAST  = 2'd2,
    ERR_TMO        = 2'd3
  } ivs_err_e;

endpackage

// File: rtl/ivs_cmd_decode.sv
// Combinational field decode of a slot command descriptor (words 0..5).
module ivs_cmd_decode #(
  parameter int unsigned CMD_WORDS = 6
) (
  input  logic [CMD_WORDS*32-1:0] cmd_raw_i,
  output logic [2:0]              frm_mode_o,
  output logic [2:0]              frm_format_o,
  output logic [15:0]             frm_line_stride_o,
  output logic [15:0]             frm_width_o,
  output logic [15:0]             frm_height_o,
  output logic [15:0]             frm_x_steps_o,
  output logic [15:0]             frm_y_steps_o,
  output logic [31:0]             frm_i_base_o,
  output logic [31:0]             frm_o_base_o,
  output logic [15:0]             frm_x_stride_o,
  output logic [15:0]             frm_y_stride_o
);

  assign frm_mode_o        = cmd_raw_i[2:0];
  assign frm_format_o      = cmd_raw_i[5:3];
  assign frm_line_stride_o = cmd_raw_i[31:16];
  assign frm_width_o       = cmd_raw_i[47:32];
  assign frm_height_o      = cmd_raw_i[63:48];
  assign frm_x_steps_o     = cmd_raw_i[79:64];
  assign frm_y_steps_o     = cmd_raw_i[95:80];
  assign frm_i_base_o      = cmd_raw_i[127:96];
  assign frm_o_base_o      = cmd_raw_i[159:128];
  assign frm_x_stride_o    = cmd_raw_i[175:160];
  assign frm_y_stride_o    = cmd_raw_i[191:176];

  // w0[15:6] and any words past w5 are carried in cmd_raw only.
  logic unused_w0;
  assign unused_w0 = ^cmd_raw_i[15:6];

  if (CMD_WORDS > 6) begin : g_extra
    logic unused_hi;
    assign unused_hi = ^cmd_raw_i[CMD_WORDS*32-1:192];
  end

endmodule

// File: rtl/ivs_slot_cmd_fetch.sv
// Slot command fetcher: one burst read per slot, descriptor assembly, framing checks.
// Optional data-phase watchdog enabled by defining IVS_CMD_TMO_EN.
module ivs_slot_cmd_fetch
  import ivs_pkg::*;
#(
  parameter int unsigned DW               = 64,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned SLOT_W           = 5,
  parameter int unsigned CMD_WORDS        = 6,
  parameter int unsigned SLOT_STRIDE_LOG2 = 5,
  parameter int unsigned TMO_CYC          = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       cmd_base,
  input  logic                    fetch_vld,
  input  logic [SLOT_W-1:0]       fetch_slot,
  output logic                    fetch_rdy,
  output logic                    ar_vld,
  input  logic                    ar_rdy,
  output logic [ADDR_W-1:0]       ar_addr,
  output logic [7:0]              ar_len,
  input  logic                    r_vld,
  input  logic                    r_last,
  input  logic [DW-1:0]           r_data,
  output logic                    r_rdy,
  output logic                    cmd_vld,
  input  logic                    cmd_rdy,
  output logic                    cmd_err,
  output logic [1:0]              cmd_err_code,
  output logic [SLOT_W-1:0]       cmd_slot,
  output logic [CMD_WORDS*32-1:0] cmd_raw,
  output logic [2:0]              frm_mode,
  output logic [2:0]              frm_format,
  output logic [15:0]             frm_line_stride,
  output logic [15:0]             frm_width,
  output logic [15:0]             frm_height,
  output logic [15:0]             frm_x_steps,
  output logic [15:0]             frm_y_steps,
  output logic [31:0]             frm_i_base,
  output logic [31:0]             frm_o_base,
  output logic [15:0]             frm_x_stride,
  output logic [15:0]             frm_y_stride
);

  localparam int unsigned RAW_W  = CMD_WORDS * 32;
  localparam int unsigned BEATS  = RAW_W / DW;
  localparam int unsigned BCNT_W = $clog2(BEATS + 1);

  ivs_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [RAW_W-1:0]  raw_q, raw_d;
  logic [BCNT_W-1:0] beat_q, beat_d;
  ivs_err_e          err_q, err_d;
  logic              fetch_rdy_q, ar_vld_q, r_rdy_q, cmd_vld_q, cmd_err_q;
  logic              tmo_hit_c;

`ifdef IVS_CMD_TMO_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Idle-cycle counter for the data phase; any beat restarts it.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_DATA && !r_vld) begin
      tmo_d = (tmo_q == TMO_W'(TMO_CYC)) ? tmo_q : tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit_c = (state_q == ST_DATA) && !r_vld && (tmo_q == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  localparam int unsigned tmo_cyc_unused = TMO_CYC;
  assign tmo_hit_c = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    slot_d  = slot_q;
    raw_d   = raw_q;
    beat_d  = beat_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_vld) begin
          addr_d  = cmd_base + (ADDR_W'(fetch_slot) << SLOT_STRIDE_LOG2);
          slot_d  = fetch_slot;
          beat_d  = '0;
          err_d   = ERR_NONE;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (ar_rdy) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (r_vld) begin
          if (beat_q < BCNT_W'(BEATS)) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
              if (beat_q == BCNT_W'(b)) raw_d[b*DW +: DW] = r_data;
            end
            beat_d = beat_q + BCNT_W'(1);
          end
          if (r_last) begin
            if (beat_q < BCNT_W'(BEATS - 1) && err_q == ERR_NONE) err_d = ERR_EARLY_LAST;
            state_d = ST_OUT;
          end else if (beat_q == BCNT_W'(BEATS - 1) && err_q == ERR_NONE) begin
            err_d = ERR_MISS_LAST;
          end
        end else if (tmo_hit_c) begin
          if (err_q == ERR_NONE) err_d = ERR_TMO;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (cmd_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      slot_q      <= '0;
      raw_q       <= '0;
      beat_q      <= '0;
      err_q       <= ERR_NONE;
      fetch_rdy_q <= 1'b1;
      ar_vld_q    <= 1'b0;
      r_rdy_q     <= 1'b1;
      cmd_vld_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      slot_q      <= slot_d;
      raw_q       <= raw_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      fetch_rdy_q <= (state_d == ST_IDLE);
      ar_vld_q    <= (state_d == ST_AR);
      r_rdy_q     <= (state_d != ST_AR);
      cmd_vld_q   <= (state_d == ST_OUT);
      cmd_err_q   <= (err_d != ERR_NONE);
    end
  end

  assign fetch_rdy    = fetch_rdy_q;
  assign ar_vld       = ar_vld_q;
  assign ar_addr      = addr_q;
  assign ar_len       = 8'(BEATS - 1);
  assign r_rdy        = r_rdy_q;
  assign cmd_vld      = cmd_vld_q;
  assign cmd_err      = cmd_err_q;
  assign cmd_err_code = err_q;
  assign cmd_slot     = slot_q;
  assign cmd_raw      = raw_q;

  ivs_cmd_decode #(.CMD_WORDS(CMD_WORDS)) u_decode (
    .cmd_raw_i         (raw_q),
    .frm_mode_o        (frm_mode),
    .frm_format_o      (frm_format),
    .frm_line_stride_o (frm_line_stride),
    .frm_width_o       (frm_width),
    .frm_height_o      (frm_height),
    .frm_x_steps_o     (frm_x_steps),
    .frm_y_steps_o     (frm_y_steps),
    .frm_i_base_o      (frm_i_base),
    .frm_o_base_o      (frm_o_base),
    .frm_x_stride_o    (frm_x_stride),
    .frm_y_stride_o    (frm_y_stride)
  );

endmodule

// File: tb/tb_ivs_slot_cmd_fetch.sv
// Bench for ivs_slot_cmd_fetch: directed plus randomized transactions vs a word-array model.
// The watchdog case runs only when IVS_CMD_TMO_EN is defined.
module tb_ivs_slot_cmd_fetch;

  localparam int unsigned BEATS = 3;
  localparam int unsigned WPB   = 2;
  localparam int unsigned NW    = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_base;
  logic        fetch_vld;
  logic [4:0]  fetch_slot;
  logic        fetch_rdy, ar_vld, ar_rdy, r_vld, r_last, r_rdy, cmd_vld, cmd_rdy, cmd_err;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [63:0] r_data;
  logic [1:0]  cmd_err_code;
  logic [4:0]  cmd_slot;
  logic [191:0] cmd_raw;
  logic [2:0]  frm_mode, frm_format;
  logic [15:0] frm_line_stride, frm_width, frm_height, frm_x_steps, frm_y_steps;
  logic [31:0] frm_i_base, frm_o_base;
  logic [15:0] frm_x_stride, frm_y_stride;

  // Second instance: 128-bit bus, 8-word descriptor, address arithmetic only.
  logic        rst_b, fetch_vld_b, fetch_rdy_b, ar_vld_b, r_rdy_b, cmd_vld_b, cmd_err_b;
  logic [31:0] cmd_base_b, ar_addr_b;
  logic [4:0]  fetch_slot_b, cmd_slot_b;
  logic [7:0]  ar_len_b;
  logic [1:0]  cmd_err_code_b;
  logic [255:0] cmd_raw_b;
  logic [2:0]  mode_b, format_b;
  logic [15:0] ls_b, w_b, h_b, xs_b, ys_b, xst_b, yst_b;
  logic [31:0] ib_b, ob_b;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] mw [NW];

  always #5 clk = ~clk;

  ivs_slot_cmd_fetch #(.DW(64), .ADDR_W(32), .SLOT_W(5), .CMD_WORDS(6),
                       .SLOT_STRIDE_LOG2(5), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst), .cmd_base(cmd_base), .fetch_vld(fetch_vld), .fetch_slot(fetch_slot),
    .fetch_rdy(fetch_rdy), .ar_vld(ar_vld), .ar_rdy(ar_rdy), .ar_addr(ar_addr), .ar_len(ar_len),
    .r_vld(r_vld), .r_last(r_last), .r_data(r_data), .r_rdy(r_rdy), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .cmd_err(cmd_err), .cmd_err_code(cmd_err_code), .cmd_slot(cmd_slot),
    .cmd_raw(cmd_raw), .frm_mode(frm_mode), .frm_format(frm_format),
    .frm_line_stride(frm_line_stride), .frm_width(frm_width), .frm_height(frm_height),
    .frm_x_steps(frm_x_steps), .frm_y_steps(frm_y_steps), .frm_i_base(frm_i_base),
    .frm_o_base(frm_o_base), .frm_x_stride(frm_x_stride), .frm_y_stride(frm_y_stride)
  );

  ivs_slot_cmd_fetch #(.DW(128), .ADDR_W(32), .SLOT_W(5), .CMD_WORDS(8),
                       .SLOT_STRIDE_LOG2(5), .TMO_CYC(16)) dut_b (
    .clk(clk), .rst(rst_b), .cmd_base(cmd_base_b), .fetch_vld(fetch_vld_b),
    .fetch_slot(fetch_slot_b), .fetch_rdy(fetch_rdy_b), .ar_vld(ar_vld_b), .ar_rdy(1'b0),
    .ar_addr(ar_addr_b), .ar_len(ar_len_b), .r_vld(1'b0), .r_last(1'b0), .r_data(128'd0),
    .r_rdy(r_rdy_b), .cmd_vld(cmd_vld_b), .cmd_rdy(1'b0), .cmd_err(cmd_err_b),
    .cmd_err_code(cmd_err_code_b), .cmd_slot(cmd_slot_b), .cmd_raw(cmd_raw_b),
    .frm_mode(mode_b), .frm_format(format_b), .frm_line_stride(ls_b), .frm_width(w_b),
    .frm_height(h_b), .frm_x_steps(xs_b), .frm_y_steps(ys_b), .frm_i_base(ib_b),
    .frm_o_base(ob_b), .frm_x_stride(xst_b), .frm_y_stride(yst_b)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [191:0] model_raw();
    logic [191:0] r;
    for (int i = 0; i < NW; i++) r[i*32 +: 32] = mw[i];
    return r;
  endfunction

  task automatic stray();
    r_vld  = 1'($urandom_range(0, 1));
    r_last = 1'($urandom_range(0, 1));
    r_data = {$urandom, $urandom};
  endtask

  task automatic check_cmd(input logic [4:0] slot, input logic [1:0] err);
    chk("cmd_vld", cmd_vld, 1'b1);
    chk("cmd_err", cmd_err, err != 2'd0);
    chk("cmd_err_code", cmd_err_code, err);
    chk("cmd_slot", cmd_slot, slot);
    chk("cmd_raw", cmd_raw, model_raw());
    chk("frm_mode", frm_mode, mw[0][2:0]);
    chk("frm_format", frm_format, mw[0][5:3]);
    chk("frm_line_stride", frm_line_stride, mw[0][31:16]);
    chk("frm_width", frm_width, mw[1][15:0]);
    chk("frm_height", frm_height, mw[1][31:16]);
    chk("frm_x_steps", frm_x_steps, mw[2][15:0]);
    chk("frm_y_steps", frm_y_steps, mw[2][31:16]);
    chk("frm_i_base", frm_i_base, mw[3]);
    chk("frm_o_base", frm_o_base, mw[4]);
    chk("frm_x_stride", frm_x_stride, mw[5][15:0]);
    chk("frm_y_stride", frm_y_stride, mw[5][31:16]);
  endtask

  // One fetch with n beats (r_last on the n-th); the model writes only the first BEATS beats.
  task automatic run_txn(input logic [31:0] base, input logic [4:0] slot, input int n,
                         input int ar_dly, input int cmd_dly, input int gap_max,
                         input bit use_b0, input logic [63:0] b0);
    logic [31:0] exp_addr;
    logic [1:0]  exp_err;
    logic [63:0] d;
    int lat;
    chk("fetch_rdy idle", fetch_rdy, 1'b1);
    cmd_base = base; fetch_slot = slot; fetch_vld = 1'b1; stray();
    exp_addr = base + ({27'd0, slot} << 5);
    exp_err  = (n < BEATS) ? 2'd1 : (n > BEATS) ? 2'd2 : 2'd0;
    @(negedge clk); lat = 1; fetch_vld = 1'b0;
    chk("ar_vld", ar_vld, 1'b1);
    chk("ar_addr", ar_addr, exp_addr);
    chk("ar_len", ar_len, 8'd2);
    chk("r_rdy in ar", r_rdy, 1'b0);
    chk("fetch_rdy busy", fetch_rdy, 1'b0);
    repeat (ar_dly) begin
      ar_rdy = 1'b0; stray();
      @(negedge clk); lat++;
      chk("ar_vld hold", ar_vld, 1'b1);
      chk("ar_addr hold", ar_addr, exp_addr);
    end
    ar_rdy = 1'b1; stray();
    @(negedge clk); lat++; ar_rdy = 1'b0; r_vld = 1'b0;
    chk("ar_vld drop", ar_vld, 1'b0);
    chk("r_rdy in data", r_rdy, 1'b1);
    for (int b = 0; b < n; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        r_vld = 1'b0; r_last = 1'($urandom_range(0, 1)); r_data = {$urandom, $urandom};
        @(negedge clk); lat++;
      end
      d = (use_b0 && b == 0) ? b0 : {$urandom, $urandom};
      r_vld = 1'b1; r_data = d; r_last = (b == n - 1);
      if (b < BEATS) for (int w = 0; w < WPB; w++) mw[b*WPB + w] = d[w*32 +: 32];
      @(negedge clk); lat++;
      if (b != n - 1) chk("cmd_vld low in data", cmd_vld, 1'b0);
    end
    r_vld = 1'b0; r_last = 1'b0;
    check_cmd(slot, exp_err);
    if (n == BEATS && ar_dly == 0 && gap_max == 0) chk("request latency", lat, 5);
    repeat (cmd_dly) begin
      cmd_rdy = 1'b0; stray();
      @(negedge clk);
      chk("cmd_vld hold", cmd_vld, 1'b1);
      chk("cmd_raw hold", cmd_raw, model_raw());
      chk("cmd_err_code hold", cmd_err_code, exp_err);
    end
    cmd_rdy = 1'b1; stray();
    @(negedge clk); cmd_rdy = 1'b0; r_vld = 1'b0;
    chk("cmd_vld drop", cmd_vld, 1'b0);
    chk("fetch_rdy after pop", fetch_rdy, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    cmd_base = '0; fetch_vld = 1'b0; fetch_slot = '0; ar_rdy = 1'b0;
    r_vld = 1'b0; r_last = 1'b0; r_data = '0; cmd_rdy = 1'b0;
    cmd_base_b = '0; fetch_vld_b = 1'b0; fetch_slot_b = '0;
    for (int i = 0; i < NW; i++) mw[i] = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst fetch_rdy", fetch_rdy, 1'b1);
    chk("rst ar_vld", ar_vld, 1'b0);
    chk("rst cmd_vld", cmd_vld, 1'b0);
    chk("rst cmd_err", cmd_err, 1'b0);
    chk("rst cmd_err_code", cmd_err_code, 2'd0);
    chk("rst ar_addr", ar_addr, 32'd0);
    chk("rst cmd_slot", cmd_slot, 5'd0);
    chk("rst cmd_raw", cmd_raw, 192'd0);
    chk("rst frm_i_base", frm_i_base, 32'd0);
    chk("rst r_rdy", r_rdy, 1'b1);
    rst = 1'b0;

    // wide-bus instance: address at the top of the space, then wrap-around
    rst_b = 1'b0; cmd_base_b = 32'hFFFF_FC00; fetch_slot_b = 5'd31; fetch_vld_b = 1'b1;
    @(negedge clk); fetch_vld_b = 1'b0;
    chk("b ar_vld", ar_vld_b, 1'b1);
    chk("b ar_addr", ar_addr_b, 32'hFFFF_FFE0);
    chk("b ar_len", ar_len_b, 8'd1);
    rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0; cmd_base_b = 32'hFFFF_FFF0; fetch_vld_b = 1'b1;
    @(negedge clk); fetch_vld_b = 1'b0;
    chk("b ar_addr wrap", ar_addr_b, 32'h0000_03D0);

    // nominal fetch with known w0
    run_txn(32'h1000_0000, 5'd3, 3, 0, 0, 0, 1'b1, {32'h1234_5678, 32'h0280_002A});
    chk("dir ar_addr", ar_addr, 32'h1000_0060);
    chk("dir frm_mode", frm_mode, 3'd2);
    chk("dir frm_format", frm_format, 3'd5);
    chk("dir frm_line_stride", frm_line_stride, 16'h0280);

    // early last on beat 1, held output
    run_txn(32'h1000_0000, 5'd9, 2, 0, 4, 0, 1'b0, '0);
    // missing last: 4 beats, last on the 4th
    run_txn(32'h2000_0100, 5'd1, 4, 0, 0, 0, 1'b0, '0);
    // backpressure, then back-to-back request
    run_txn(32'h3000_0000, 5'd17, 3, 7, 10, 0, 1'b0, '0);
    run_txn(32'h3000_0000, 5'd18, 3, 0, 0, 0, 1'b0, '0);

    // reset in the data phase; later beats are dropped
    cmd_base = 32'h2000_0000; fetch_slot = 5'd7; fetch_vld = 1'b1;
    @(negedge clk); fetch_vld = 1'b0; ar_rdy = 1'b1;
    @(negedge clk); ar_rdy = 1'b0; r_vld = 1'b1; r_last = 1'b0; r_data = {$urandom, $urandom};
    @(negedge clk); rst = 1'b1; r_data = {$urandom, $urandom};
    @(negedge clk); rst = 1'b0; r_last = 1'b1; r_data = {$urandom, $urandom};
    for (int i = 0; i < NW; i++) mw[i] = '0;
    chk("mid rst fetch_rdy", fetch_rdy, 1'b1);
    chk("mid rst ar_addr", ar_addr, 32'd0);
    chk("mid rst cmd_vld", cmd_vld, 1'b0);
    @(negedge clk); r_vld = 1'b0; r_last = 1'b0;
    chk("mid rst raw dropped", cmd_raw, 192'd0);
    chk("mid rst still idle", fetch_rdy, 1'b1);

`ifdef IVS_CMD_TMO_EN
    begin
      int k;
      cmd_base = 32'h4000_0000; fetch_slot = 5'd5; fetch_vld = 1'b1;
      @(negedge clk); fetch_vld = 1'b0; ar_rdy = 1'b1;
      k = 0;
      do begin
        @(negedge clk); ar_rdy = 1'b0; k++;
      end while (!cmd_vld && k < 40);
      // 16 empty data cycles, then the descriptor is presented
      chk("tmo latency", k, 17);
      check_cmd(5'd5, 2'd3);
      r_vld = 1'b1; r_last = 1'b1; r_data = {$urandom, $urandom};
      @(negedge clk); r_vld = 1'b0; r_last = 1'b0;
      chk("tmo stray dropped", cmd_raw, model_raw());
      cmd_rdy = 1'b1;
      @(negedge clk); cmd_rdy = 1'b0;
      chk("tmo cmd_vld drop", cmd_vld, 1'b0);
    end
`endif

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      run_txn($urandom, 5'($urandom_range(0, 31)), $urandom_range(1, 6),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
